// File: rtl/mic_rsp_router.sv
// Read-response router: steers memory read beats into per-requester response
// FIFOs by address partition, and tracks beats dropped on full lanes.
module mic_rsp_router #(
  parameter int NREQS  = 4,
  parameter int PSIZE  = 64,
  parameter int AWIDTH = $clog2(NREQS*PSIZE),
  parameter int MWIDTH = 32,
  parameter int RDEPTH = 4,
  parameter int RBITS  = $clog2(NREQS),
  parameter int OWIDTH = AWIDTH-RBITS
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rdata_valid,
  input  logic [AWIDTH-1:0] mem_addr,
  input  logic [MWIDTH-1:0] mem_rdata,
  input  logic [NREQS-1:0]  rsp_ready,
  input  logic              clr_status,
  output logic [NREQS-1:0]  rsp_valid,
  output logic [MWIDTH-1:0] rsp_data   [0:NREQS-1],
  output logic [OWIDTH-1:0] rsp_offset [0:NREQS-1],
  output logic [NREQS-1:0]  rsp_overflow,
  output logic [15:0]       drop_count
);

  localparam int PWIDTH = $clog2(RDEPTH);
  localparam int CWIDTH = $clog2(RDEPTH) + 1;
  localparam int EWIDTH = OWIDTH + MWIDTH;

  logic [RBITS-1:0]  w_lane;
  logic [OWIDTH-1:0] w_offset;
  logic [NREQS-1:0]  w_drop;
  logic              w_any_drop;

  logic [NREQS-1:0]  r_overflow;
  logic [15:0]       r_drop_count;

  assign w_lane     = mem_addr[AWIDTH-1 -: RBITS];
  assign w_offset   = mem_addr[OWIDTH-1:0];
  assign w_any_drop = |w_drop;

  for (genvar i = 0; i < NREQS; i++) begin : g_lane
    logic [EWIDTH-1:0] r_mem [RDEPTH];
    logic [PWIDTH-1:0] r_rd_ptr;
    logic [PWIDTH-1:0] r_wr_ptr;
    logic [CWIDTH-1:0] r_count;
    logic              w_hit;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic [EWIDTH-1:0] w_head;

    assign w_hit  = rdata_valid && (w_lane == RBITS'(i));
    assign w_full = (r_count == CWIDTH'(RDEPTH));
    assign w_pop  = rsp_valid[i] && rsp_ready[i];
    // A full lane still accepts when its head leaves on the same edge.
    assign w_push = w_hit && (!w_full || w_pop);
    assign w_drop[i] = w_hit && w_full && !w_pop;
    assign w_head = r_mem[r_rd_ptr];

    assign rsp_valid[i]  = (r_count != '0);
    assign rsp_data[i]   = rsp_valid[i] ? w_head[MWIDTH-1:0] : '0;
    assign rsp_offset[i] = rsp_valid[i] ? w_head[EWIDTH-1:MWIDTH] : '0;

    // Storage is not reset; empty lanes are masked at the outputs.
    always_ff @(posedge clock) begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {w_offset, mem_rdata};
      end
    end

    // Pointer and occupancy bookkeeping; pointers wrap at the power-of-two depth.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PWIDTH'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PWIDTH'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CWIDTH'(1);
          2'b01:   r_count <= r_count - CWIDTH'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Sticky drop flags and saturating drop counter; a same-cycle drop survives a clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow   <= '0;
      r_drop_count <= '0;
    end else if (clr_status) begin
      r_overflow   <= w_drop;
      r_drop_count <= w_any_drop ? 16'd1 : 16'd0;
    end else begin
      r_overflow <= r_overflow | w_drop;
      if (w_any_drop && (r_drop_count != 16'hFFFF)) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

  assign rsp_overflow = r_overflow;
  assign drop_count   = r_drop_count;

endmodule

// File: tb/tb_mic_rsp_router.sv
// Bench for mic_rsp_router: directed scenarios followed by random traffic,
// all checked against per-lane queue model.
module tb_mic_rsp_router;

  localparam int NREQS  = 4;
  localparam int PSIZE  = 64;
  localparam int AWIDTH = 8;
  localparam int MWIDTH = 32;
  localparam int RDEPTH = 4;
  localparam int OWIDTH = 6;

  logic              clock;
  logic              reset_n;
  logic              rdata_valid;
  logic [AWIDTH-1:0] mem_addr;
  logic [MWIDTH-1:0] mem_rdata;
  logic [NREQS-1:0]  rsp_ready;
  logic              clr_status;
  logic [NREQS-1:0]  rsp_valid;
  logic [MWIDTH-1:0] rsp_data   [0:NREQS-1];
  logic [OWIDTH-1:0] rsp_offset [0:NREQS-1];
  logic [NREQS-1:0]  rsp_overflow;
  logic [15:0]       drop_count;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one queue of {offset,data} per lane, plus status.
  logic [37:0]      mq [NREQS][$];
  logic [NREQS-1:0] m_ov;
  int               m_dc;

  mic_rsp_router #(
    .NREQS (NREQS),
    .PSIZE (PSIZE),
    .MWIDTH(MWIDTH),
    .RDEPTH(RDEPTH)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rdata_valid (rdata_valid),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .rsp_ready   (rsp_ready),
    .clr_status  (clr_status),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_offset  (rsp_offset),
    .rsp_overflow(rsp_overflow),
    .drop_count  (drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int l = 0; l < NREQS; l++) mq[l].delete();
    m_ov = '0;
    m_dc = 0;
  endtask

  // Apply one clock edge's worth of behaviour to the model.
  task automatic model_edge(input logic v, input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] rdy, input logic c);
    int          lane;
    logic        pop;
    logic        drop;
    lane = int'(a) / PSIZE;
    drop = 1'b0;
    pop  = (mq[lane].size() != 0) && rdy[lane];
    for (int l = 0; l < NREQS; l++) begin
      if (mq[l].size() != 0 && rdy[l]) void'(mq[l].pop_front());
    end
    if (v) begin
      if (mq[lane].size() < RDEPTH || pop) mq[lane].push_back({a[5:0], d});
      else drop = 1'b1;
    end
    if (c) begin
      m_ov = '0;
      m_dc = 0;
    end
    if (drop) begin
      m_ov[lane] = 1'b1;
      if (m_dc < 65535) m_dc++;
    end
  endtask

  task automatic check_all();
    for (int l = 0; l < NREQS; l++) begin
      logic [37:0] h;
      h = (mq[l].size() != 0) ? mq[l][0] : 38'd0;
      chk($sformatf("valid[%0d]", l), rsp_valid[l], mq[l].size() != 0);
      chk($sformatf("data[%0d]", l), rsp_data[l], h[31:0]);
      chk($sformatf("offset[%0d]", l), rsp_offset[l], h[37:32]);
    end
    chk("overflow", rsp_overflow, m_ov);
    chk("drop_count", drop_count, m_dc);
  endtask

  // Called just after a falling edge: drive, cross one rising edge, check at next falling edge.
  task automatic step(input logic v, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] rdy, input logic c);
    rdata_valid = v;
    mem_addr    = a;
    mem_rdata   = d;
    rsp_ready   = rdy;
    clr_status  = c;
    model_edge(v, a, d, rdy, c);
    @(posedge clock);
    @(negedge clock);
    rdata_valid = 1'b0;
    rsp_ready   = '0;
    clr_status  = 1'b0;
    check_all();
  endtask

  task automatic idle(input logic [3:0] rdy);
    step(1'b0, 8'h00, 32'h0, rdy, 1'b0);
  endtask

  initial begin
    reset_n     = 1'b0;
    rdata_valid = 1'b0;
    mem_addr    = '0;
    mem_rdata   = '0;
    rsp_ready   = '0;
    clr_status  = 1'b0;
    model_clear();
    #2;
    chk("reset_valid", rsp_valid, 4'b0000);
    chk("reset_drop_count", drop_count, 16'd0);
    chk("reset_overflow", rsp_overflow, 4'b0000);
    @(negedge clock);
    reset_n = 1'b1;

    // Single beat to lane 2, offset 5.
    step(1'b1, 8'h85, 32'hDEADBEEF, 4'b0000, 1'b0);
    chk("single_valid", rsp_valid, 4'b0100);
    chk("single_data", rsp_data[2], 32'hDEADBEEF);
    chk("single_offset", rsp_offset[2], 6'd5);
    idle(4'b0100);
    chk("single_drained", rsp_valid, 4'b0000);

    // Ordering on lane 1.
    for (int k = 1; k <= 4; k++) step(1'b1, 8'(8'h40 + k), 32'(k), 4'b0000, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      chk("order_data", rsp_data[1], 32'(k));
      idle(4'b0010);
    end
    chk("order_empty", rsp_valid[1], 1'b0);

    // Ready on an empty lane has no effect.
    idle(4'b1111);

    // Overflow on lane 0.
    for (int k = 1; k <= 5; k++) step(1'b1, 8'(k), 32'(8'hA0 + k), 4'b0000, 1'b0);
    chk("ovf_flag", rsp_overflow, 4'b0001);
    chk("ovf_count", drop_count, 16'd1);
    for (int k = 1; k <= 4; k++) begin
      chk("ovf_drain", rsp_data[0], 32'(8'hA0 + k));
      idle(4'b0001);
    end
    chk("ovf_empty", rsp_valid[0], 1'b0);

    // Full lane 3 with a simultaneous pop.
    for (int k = 1; k <= 4; k++) step(1'b1, 8'(8'hC0 + k), 32'(30 + k), 4'b0000, 1'b0);
    step(1'b1, 8'hC9, 32'd35, 4'b1000, 1'b0);
    chk("fullpop_count", drop_count, 16'd1);
    for (int k = 2; k <= 5; k++) begin
      chk("fullpop_order", rsp_data[3], 32'(30 + k));
      idle(4'b1000);
    end
    chk("fullpop_empty", rsp_valid[3], 1'b0);

    // Clear versus drop on lane 2 with drop_count at 7.
    step(1'b0, 8'h00, 32'h0, 4'b0000, 1'b1);
    for (int k = 0; k < 11; k++) step(1'b1, 8'(8'h80 + k), 32'(100 + k), 4'b0000, 1'b0);
    chk("clr_pre_count", drop_count, 16'd7);
    step(1'b1, 8'h8F, 32'd200, 4'b0000, 1'b1);
    chk("clr_drop_count", drop_count, 16'd1);
    chk("clr_drop_flag", rsp_overflow, 4'b0100);
    for (int k = 0; k < 4; k++) idle(4'b0100);

    // Reset mid-stream.
    for (int k = 0; k < 3; k++) step(1'b1, 8'(8'h10 + k), 32'(500 + k), 4'b0000, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_valid", rsp_valid, 4'b0000);
    chk("rst_async_data", rsp_data[0], 32'd0);
    chk("rst_async_count", drop_count, 16'd0);
    model_clear();
    #1 reset_n = 1'b1;
    @(negedge clock);
    check_all();
    step(1'b1, 8'h22, 32'h0000CAFE, 4'b0000, 1'b0);
    chk("rst_first", rsp_data[0], 32'h0000CAFE);
    idle(4'b0001);
    chk("rst_alone", rsp_valid[0], 1'b0);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom, 4'($urandom),
           $urandom_range(0, 40) == 0);
    end
    for (int n = 0; n < RDEPTH; n++) idle(4'b1111);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mic_rsp_router.md
MIC_RSP_ROUTER -- requirements
Module: mic_rsp_router

Interface
REQ-001 Parameter NREQS, default 4: number of requesters and response lanes.
REQ-002 Parameter PSIZE, default 64: words per requester partition; a power of two.
REQ-003 Parameter AWIDTH, default $clog2(NREQS*PSIZE): memory address width.
REQ-004 Parameter MWIDTH, default 32: data word width.
REQ-005 Parameter RDEPTH, default 4: entries per lane response FIFO; a power of two, at least 2.
REQ-006 Parameter RBITS, default $clog2(NREQS): lane index width.
REQ-007 Parameter OWIDTH, default AWIDTH-RBITS: partition offset width.
REQ-008 Port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-009 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-010 Port rdata_valid, input, 1: read beat from the memory interface controller is valid this cycle.
REQ-011 Port mem_addr, input, AWIDTH: address of the read beat.
REQ-012 Port mem_rdata, input, MWIDTH: data of the read beat.
REQ-013 Port rsp_ready, input, NREQS: per-lane consumer ready.
REQ-014 Port clr_status, input, 1: synchronous clear of overflow and drop status.
REQ-015 Port rsp_valid, output, NREQS: per-lane response available.
REQ-016 Port rsp_data, output, MWIDTH x [0:NREQS-1]: per-lane head data word.
REQ-017 Port rsp_offset, output, OWIDTH x [0:NREQS-1]: per-lane head offset within its partition.
REQ-018 Port rsp_overflow, output, NREQS: sticky per-lane drop flag.
REQ-019 Port drop_count, output, 16: saturating total count of dropped beats.

Function
REQ-020 Lane select SHALL be mem_addr[AWIDTH-1 -: RBITS], and the offset SHALL be mem_addr[OWIDTH-1:0].
REQ-021 A beat with rdata_valid=1 SHALL be written as {offset, data} into the selected lane FIFO at the same rising edge.
REQ-022 Latency: a beat into an empty lane SHALL assert rsp_valid for that lane in the cycle after the capture edge.
REQ-023 rsp_valid[i] SHALL equal "lane i FIFO non-empty"; rsp_data[i] and rsp_offset[i] SHALL show the head entry and SHALL be zero when the lane is empty.
REQ-024 Pop SHALL occur at an edge where rsp_valid[i] and rsp_ready[i] are both 1; only one pop per lane per cycle is allowed.
REQ-025 Responses within a lane SHALL leave in arrival order; lanes SHALL be independent of each other.
REQ-026 A beat to a full lane with no pop that cycle SHALL be dropped, set rsp_overflow for that lane, and increment drop_count.
REQ-027 A beat to a full lane that is popped in the same cycle SHALL be accepted; occupancy stays RDEPTH and there is no drop.
REQ-028 A push and pop on a non-full, non-empty lane in the same cycle SHALL leave occupancy unchanged.
REQ-029 Read and write pointers SHALL wrap modulo RDEPTH; occupancy SHALL be tracked with a $clog2(RDEPTH)+1 bit counter.
REQ-030 drop_count SHALL saturate at 16'hFFFF.
REQ-031 clr_status SHALL zero rsp_overflow and drop_count at the next edge; a drop in the same cycle SHALL leave its flag set and drop_count=1.
REQ-032 A rsp_ready input with the lane empty SHALL have no effect.

Reset
REQ-033 reset_n=0 SHALL immediately, and independent of clock, empty all FIFOs and zero rsp_valid, rsp_data, rsp_offset, rsp_overflow and drop_count.
REQ-034 Reset asserted mid-operation SHALL discard all buffered beats; after release, the first accepted beat SHALL be the first one delivered.
REQ-035 FIFO storage contents need no reset, because outputs are masked to zero while a lane is empty.

Verification
REQ-036 Single beat: rdata_valid with mem_addr=0x85, mem_rdata=0xDEADBEEF, and rsp_ready=0 -> next cycle rsp_valid=4'b0100, rsp_data[2]=0xDEADBEEF, rsp_offset[2]=5.
REQ-037 Order: 4 beats to lane 1 (data 1,2,3,4), then rsp_ready[1]=1 -> data 1,2,3,4 on 4 consecutive cycles, then rsp_valid[1]=0.
REQ-038 Overflow: 5 beats to lane 0 with rsp_ready=0 -> 5th beat dropped, rsp_overflow=4'b0001, drop_count=1, and after draining data is beats 1-4.
REQ-039 Full with simultaneous pop: lane 3 full, one beat arrives while rsp_ready[3]=1 -> no drop, and the new beat is delivered 4th.
REQ-040 Clear versus drop: clr_status=1 in the same cycle as a drop on lane 2, with drop_count previously 7 -> drop_count=1, rsp_overflow=4'b0100.
REQ-041 Reset mid-stream: 3 beats buffered on lane 0, pulse reset_n low between edges -> rsp_valid=0 immediately, and the next beat after release is delivered alone.
